mem_access_master: RTL and testbench



---
 rtl/mem_pkg.sv | 26 ++
 rtl/mem_access_master_if.sv | 42 ++++
 rtl/mem_req_check.sv | 38 +++
 rtl/mem_access_master.sv | 124 ++++++++++++
 tb/tb_mem_access_master.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory access master.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state enum, ROM/RAM boundary, word size, request error-cause indices.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } mem_state_e;

  // Addresses below this boundary are ROM and may only be read.
  localparam logic [31:0] SEPARATOR_ADDR = 32'h1000_0000;
  localparam logic [31:0] WORD_BYTES     = 32'd4;

  // Bit positions of the individual request error causes.
  localparam int ERR_MISALIGN  = 0;
  localparam int ERR_ROM_WRITE = 1;
  localparam int ERR_WRITE_LEN = 2;
  localparam int ERR_OVERFLOW  = 3;
  localparam int ERR_STRADDLE  = 4;
  localparam int ERR_CAUSES    = 5;

endpackage

// File: rtl/mem_access_master_if.sv
// Bundles the CPU request/response channels and the memory-side bus.
// Latency: n/a (wiring only).
// Backpressure: req_ready_o / rsp_ready_i carry valid-ready flow control.
// Modports: master = the access master itself, slave = CPU plus memory environment.
interface mem_access_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LEN_W  = 3
);

  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_write_i;
  logic [DATA_WIDTH-1:0] req_addr_i;
  logic [DATA_WIDTH-1:0] req_wdata_i;
  logic [MAX_LEN_W-1:0]  req_len_i;

  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;
  logic                  rsp_err_o;
  logic                  rsp_last_o;

  logic                  mem_we_o;
  logic [DATA_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  modport master (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_len_i,
    input  rsp_ready_i, mem_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_last_o,
    output mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport slave (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_len_i,
    output rsp_ready_i, mem_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_last_o,
    input  mem_we_o, mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/mem_req_check.sv
// Flags requests that must never reach memory (bad alignment, ROM write, bad length, wrap, region straddle).
// Latency: combinational.
// Backpressure: none.
// Ports: addr_i/write_i/len_i describe the offered request; err_o is high if any check trips.
module mem_req_check
  import mem_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MAX_LEN_W  = 3,
  parameter logic [DATA_WIDTH-1:0] SEPARATOR  = DATA_WIDTH'(SEPARATOR_ADDR)
) (
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic                  write_i,
  input  logic [MAX_LEN_W-1:0]  len_i,
  output logic                  err_o
);

  logic [DATA_WIDTH:0]   span;
  logic [DATA_WIDTH:0]   end_addr;
  logic [ERR_CAUSES-1:0] cause;

  always_comb begin
    // One extra bit so a burst that wraps past the top of memory is visible.
    span     = (DATA_WIDTH+1)'(len_i) * (DATA_WIDTH+1)'(WORD_BYTES);
    end_addr = {1'b0, addr_i} + span;

    cause                = '0;
    cause[ERR_MISALIGN]  = (addr_i[1:0] != 2'b00);
    cause[ERR_ROM_WRITE] = write_i && (addr_i < SEPARATOR);
    cause[ERR_WRITE_LEN] = write_i && (len_i != '0);
    cause[ERR_OVERFLOW]  = end_addr[DATA_WIDTH];
    // First and last word of a read burst must sit in the same region.
    cause[ERR_STRADDLE]  = !write_i &&
                           ((addr_i < SEPARATOR) != (end_addr[DATA_WIDTH-1:0] < SEPARATOR));
    err_o = |cause;
  end

endmodule

// File: rtl/mem_access_master.sv
// Turns CPU read bursts / single writes into memory bus cycles and returns one response beat per word.
// Latency: read beat 2 cycles after accept (2 after each prior handshake), write ack 2, error 1.
// Backpressure: one request in flight; response held stable until rsp_ready_i, req_ready_o low while busy.
// Ports: clk, reset (async active-high), bus = mem_access_master_if.master (request, response, memory sides).
module mem_access_master
  import mem_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MAX_LEN_W  = 3,
  parameter logic [DATA_WIDTH-1:0] SEPARATOR  = DATA_WIDTH'(SEPARATOR_ADDR)
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_access_master_if.master  bus
);

  mem_state_e            state_q, state_d;
  logic [MAX_LEN_W-1:0]  cnt_q, cnt_d;
  // mem_addr_q is also the beat address; it only moves when a bus cycle is about to be issued.
  logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_last_q, rsp_last_d;
  logic                  req_err;

  mem_req_check #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_LEN_W  (MAX_LEN_W),
    .SEPARATOR  (SEPARATOR)
  ) u_check (
    .addr_i  (bus.req_addr_i),
    .write_i (bus.req_write_i),
    .len_i   (bus.req_len_i),
    .err_o   (req_err)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_last_d  = rsp_last_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          cnt_d = bus.req_len_i;
          if (req_err) begin
            // Rejected requests leave the memory bus untouched.
            rsp_err_d   = 1'b1;
            rsp_last_d  = 1'b1;
            rsp_rdata_d = '0;
            state_d     = RESP;
          end else begin
            mem_addr_d = bus.req_addr_i;
            if (bus.req_write_i) begin
              mem_wdata_d = bus.req_wdata_i;
              state_d     = WRITE;
            end else begin
              state_d = READ;
            end
          end
        end
      end
      READ: begin
        rsp_rdata_d = bus.mem_rdata_i;
        rsp_err_d   = 1'b0;
        rsp_last_d  = (cnt_q == '0);
        state_d     = RESP;
      end
      WRITE: begin
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        rsp_last_d  = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready_i) begin
          if (rsp_last_q) begin
            state_d = IDLE;
          end else begin
            cnt_d      = cnt_q - MAX_LEN_W'(1);
            mem_addr_d = mem_addr_q + DATA_WIDTH'(WORD_BYTES);
            state_d    = READ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_last_q  <= rsp_last_d;
    end
  end

  assign bus.req_ready_o = (state_q == IDLE);
  assign bus.rsp_valid_o = (state_q == RESP);
  assign bus.mem_we_o    = (state_q == WRITE);
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.rsp_rdata_o = rsp_rdata_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign bus.rsp_last_o  = rsp_last_q;

endmodule

// File: tb/tb_mem_access_master.sv
// Self-checking bench for mem_access_master: directed scenarios plus randomized traffic vs a reference model.
// Latency: n/a (testbench).
// Backpressure: drives rsp_ready_i with programmable stalls.
module tb_mem_access_master;
  import mem_pkg::*;

  localparam int DW = 32;
  localparam int LW = 3;
  localparam longint unsigned SEP = 64'h1000_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_access_master_if #(.DATA_WIDTH(DW), .MAX_LEN_W(LW)) mif();

  mem_access_master #(.DATA_WIDTH(DW), .MAX_LEN_W(LW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Memory environment seen by the DUT, and the model's independent copy.
  logic [31:0] sim_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  int          we_cnt = 0;

  function automatic logic [31:0] fill(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0F96;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : fill(a);
  endfunction

  // Writes land mid-cycle; read data follows mem_addr_o well before the capturing edge.
  always @(negedge clk) begin
    if (mif.mem_we_o === 1'b1) begin
      sim_mem[mif.mem_addr_o] = mif.mem_wdata_o;
      we_cnt++;
    end
    mif.mem_rdata_i = sim_mem.exists(mif.mem_addr_o) ? sim_mem[mif.mem_addr_o] : fill(mif.mem_addr_o);
  end

  // Reference model: is the request legal?
  function automatic bit model_err(input bit w, input logic [31:0] a, input int len);
    longint unsigned s = {32'd0, a};
    longint unsigned e = {32'd0, a} + 64'(4 * len);
    if (a % 4 != 0) return 1'b1;
    if (w && s < SEP) return 1'b1;
    if (w && len != 0) return 1'b1;
    if (e > 64'hFFFF_FFFF) return 1'b1;
    if (!w && ((s < SEP) != (e < SEP))) return 1'b1;
    return 1'b0;
  endfunction

  // Observations of one transaction.
  logic [31:0] ob_data[$];
  logic [31:0] ob_addr[$];
  logic        ob_err[$];
  logic        ob_last[$];
  int          ob_lat, ob_gap_bad, ob_busy_rdy, ob_unstable, ob_we;
  logic [31:0] ob_we_addr, ob_we_data;
  logic        ob_accept_rdy, ob_done_rdy, ob_timeout;

  task automatic run_txn(input bit back, input bit w, input logic [31:0] a, input logic [31:0] wd,
                         input int len, input int stall_beat, input int stall_cyc, input bit hold);
    int n, stall, beat, last_hs;
    bit in_beat, done;
    logic [31:0] prev_addr, h_data;
    logic h_err, h_last;
    n = 0; stall = 0; beat = 0; last_hs = 0; in_beat = 0; done = 0;
    h_data = '0; h_err = 1'b0; h_last = 1'b0;
    ob_data.delete(); ob_addr.delete(); ob_err.delete(); ob_last.delete();
    ob_lat = -1; ob_gap_bad = 0; ob_busy_rdy = 0; ob_unstable = 0; ob_we = 0;
    ob_we_addr = '0; ob_we_data = '0;
    if (!back) begin @(posedge clk); #1; end
    mif.req_valid_i = 1'b1;
    mif.req_write_i = w;
    mif.req_addr_i  = a;
    mif.req_wdata_i = wd;
    mif.req_len_i   = LW'(len);
    @(negedge clk);
    ob_accept_rdy = mif.req_ready_o;
    prev_addr = mif.mem_addr_o;
    @(posedge clk); #1;
    if (!hold) mif.req_valid_i = 1'b0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
      // Request fields wiggle while busy; the DUT must ignore them.
      mif.req_addr_i  = $urandom;
      mif.req_wdata_i = $urandom;
      mif.req_write_i = 1'($urandom_range(0, 1));
      mif.req_len_i   = LW'($urandom_range(0, 7));
      if (mif.req_ready_o !== 1'b0) ob_busy_rdy++;
      if (mif.mem_we_o === 1'b1) begin
        ob_we++;
        ob_we_addr = mif.mem_addr_o;
        ob_we_data = mif.mem_wdata_o;
      end
      if (mif.rsp_valid_o === 1'b1) begin
        if (!in_beat) begin
          in_beat = 1'b1;
          beat++;
          if (beat == 1) ob_lat = n;
          else if (n - last_hs != 2) ob_gap_bad++;
          h_data = mif.rsp_rdata_o; h_err = mif.rsp_err_o; h_last = mif.rsp_last_o;
          ob_addr.push_back(prev_addr);
          ob_data.push_back(h_data);
          ob_err.push_back(h_err);
          ob_last.push_back(h_last);
          stall = (beat == stall_beat) ? stall_cyc : 0;
        end else if (mif.rsp_rdata_o !== h_data || mif.rsp_err_o !== h_err || mif.rsp_last_o !== h_last) begin
          ob_unstable++;
        end
        if (stall > 0) begin
          stall--;
          mif.rsp_ready_i = 1'b0;
        end else begin
          mif.rsp_ready_i = 1'b1;
          in_beat = 1'b0;
          last_hs = n;
          if (mif.rsp_last_o === 1'b1) done = 1'b1;
        end
      end else begin
        mif.rsp_ready_i = 1'b0;
        prev_addr = mif.mem_addr_o;
      end
    end
    ob_timeout = !done;
    @(posedge clk); #1;
    mif.rsp_ready_i = 1'b0;
    ob_done_rdy = mif.req_ready_o;
  endtask

  task automatic test_reset();
    n_cmp++; if (mif.rsp_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", mif.rsp_valid_o); end
    n_cmp++; if (mif.rsp_err_o !== 1'b0) begin n_bad++; $display("FAIL rst_err got %b want 0", mif.rsp_err_o); end
    n_cmp++; if (mif.rsp_last_o !== 1'b0) begin n_bad++; $display("FAIL rst_last got %b want 0", mif.rsp_last_o); end
    n_cmp++; if (mif.rsp_rdata_o !== 32'h0) begin n_bad++; $display("FAIL rst_rdata got %h want 0", mif.rsp_rdata_o); end
    n_cmp++; if (mif.mem_we_o !== 1'b0) begin n_bad++; $display("FAIL rst_we got %b want 0", mif.mem_we_o); end
    n_cmp++; if (mif.mem_addr_o !== 32'h0) begin n_bad++; $display("FAIL rst_addr got %h want 0", mif.mem_addr_o); end
    n_cmp++; if (mif.mem_wdata_o !== 32'h0) begin n_bad++; $display("FAIL rst_wdata got %h want 0", mif.mem_wdata_o); end
    n_cmp++; if (mif.req_ready_o !== 1'b1) begin n_bad++; $display("FAIL rst_ready got %b want 1", mif.req_ready_o); end
  endtask

  task automatic test_read_rom();
    sim_mem[32'h8] = 32'hDEAD_BEEF;
    ref_mem[32'h8] = 32'hDEAD_BEEF;
    run_txn(1'b0, 1'b0, 32'h8, 32'h0, 0, 0, 0, 1'b0);
    n_cmp++; if (ob_timeout !== 1'b0) begin n_bad++; $display("FAIL rom_timeout got %b want 0", ob_timeout); end
    n_cmp++; if (ob_lat != 2) begin n_bad++; $display("FAIL rom_latency got %0d want 2", ob_lat); end
    n_cmp++; if (ob_data.size() != 1) begin n_bad++; $display("FAIL rom_beats got %0d want 1", ob_data.size()); end
    else begin
      n_cmp++; if (ob_addr[0] !== 32'h8) begin n_bad++; $display("FAIL rom_addr got %h want 00000008", ob_addr[0]); end
      n_cmp++; if (ob_data[0] !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rom_data got %h want deadbeef", ob_data[0]); end
      n_cmp++; if (ob_last[0] !== 1'b1 || ob_err[0] !== 1'b0) begin n_bad++; $display("FAIL rom_flags got last=%b err=%b want 1/0", ob_last[0], ob_err[0]); end
    end
    n_cmp++; if (ob_done_rdy !== 1'b1) begin n_bad++; $display("FAIL rom_ready_after got %b want 1", ob_done_rdy); end
  endtask

  task automatic test_write_ram();
    run_txn(1'b0, 1'b1, 32'h1000_0010, 32'h1234_5678, 0, 0, 0, 1'b0);
    ref_mem[32'h1000_0010] = 32'h1234_5678;
    n_cmp++; if (ob_we != 1) begin n_bad++; $display("FAIL wr_we_cycles got %0d want 1", ob_we); end
    n_cmp++; if (ob_we_addr !== 32'h1000_0010 || ob_we_data !== 32'h1234_5678) begin n_bad++; $display("FAIL wr_bus got %h/%h want 10000010/12345678", ob_we_addr, ob_we_data); end
    n_cmp++; if (ob_lat != 2 || ob_data.size() != 1) begin n_bad++; $display("FAIL wr_ack got lat=%0d beats=%0d want 2/1", ob_lat, ob_data.size()); end
    else begin
      n_cmp++; if (ob_data[0] !== 32'h0 || ob_err[0] !== 1'b0 || ob_last[0] !== 1'b1) begin n_bad++; $display("FAIL wr_ack_fields got %h/%b/%b want 0/0/1", ob_data[0], ob_err[0], ob_last[0]); end
    end
    run_txn(1'b0, 1'b0, 32'h1000_0010, 32'h0, 0, 0, 0, 1'b0);
    n_cmp++; if (ob_data.size() != 1 || ob_data[0] !== 32'h1234_5678) begin n_bad++; $display("FAIL wr_readback got %h want 12345678", ob_data.size() > 0 ? ob_data[0] : 32'hx); end
  endtask

  task automatic test_burst_stall();
    run_txn(1'b0, 1'b0, 32'h1000_0000, 32'h0, 3, 1, 3, 1'b0);
    n_cmp++; if (ob_timeout !== 1'b0 || ob_data.size() != 4) begin n_bad++; $display("FAIL burst_beats got %0d want 4", ob_data.size()); end
    for (int i = 0; i < ob_data.size(); i++) begin
      n_cmp++; if (ob_addr[i] !== 32'h1000_0000 + 32'(4 * i)) begin n_bad++; $display("FAIL burst_addr%0d got %h want %h", i, ob_addr[i], 32'h1000_0000 + 32'(4 * i)); end
      n_cmp++; if (ob_data[i] !== ref_rd(32'h1000_0000 + 32'(4 * i))) begin n_bad++; $display("FAIL burst_data%0d got %h want %h", i, ob_data[i], ref_rd(32'h1000_0000 + 32'(4 * i))); end
      n_cmp++; if (ob_last[i] !== (i == 3)) begin n_bad++; $display("FAIL burst_last%0d got %b want %b", i, ob_last[i], i == 3); end
    end
    n_cmp++; if (ob_unstable != 0) begin n_bad++; $display("FAIL burst_stable got %0d changes want 0", ob_unstable); end
    n_cmp++; if (ob_gap_bad != 0 || ob_lat != 2) begin n_bad++; $display("FAIL burst_timing got gaps_bad=%0d lat=%0d want 0/2", ob_gap_bad, ob_lat); end
    n_cmp++; if (ob_busy_rdy != 0) begin n_bad++; $display("FAIL burst_busy_ready got %0d want 0", ob_busy_rdy); end
  endtask

  task automatic test_errors();
    bit          ew[4]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] ea[4]  = '{32'h0000_0004, 32'h1000_0002, 32'h0FFF_FFFC, 32'hFFFF_FFFC};
    int          el[4]  = '{0, 0, 2, 1};
    int          we0;
    for (int i = 0; i < 4; i++) begin
      we0 = we_cnt;
      run_txn(1'b0, ew[i], ea[i], 32'hCAFE_F00D, el[i], 0, 0, 1'b0);
      n_cmp++; if (ob_lat != 1 || ob_data.size() != 1) begin n_bad++; $display("FAIL err%0d_timing got lat=%0d beats=%0d want 1/1", i, ob_lat, ob_data.size()); end
      else begin
        n_cmp++; if (ob_err[0] !== model_err(ew[i], ea[i], el[i]) || ob_last[0] !== 1'b1 || ob_data[0] !== 32'h0) begin
          n_bad++; $display("FAIL err%0d_fields got err=%b last=%b data=%h want 1/1/0", i, ob_err[0], ob_last[0], ob_data[0]);
        end
      end
      n_cmp++; if (ob_we != 0 || we_cnt != we0) begin n_bad++; $display("FAIL err%0d_we got %0d want 0", i, ob_we); end
    end
  endtask

  task automatic test_reset_mid_burst();
    int beats, n, we0;
    beats = 0; n = 0; we0 = we_cnt;
    @(posedge clk); #1;
    mif.req_valid_i = 1'b1; mif.req_write_i = 1'b0; mif.req_addr_i = 32'h1000_0100; mif.req_len_i = 3'd7;
    mif.rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    mif.req_valid_i = 1'b0;
    while (beats < 2 && n < 40) begin
      @(negedge clk);
      n++;
      if (mif.rsp_valid_o === 1'b1) beats++;
    end
    n_cmp++; if (beats != 2) begin n_bad++; $display("FAIL rmb_reach_beat2 got %0d want 2", beats); end
    #2 reset = 1'b1;
    #1;
    mif.rsp_ready_i = 1'b0;
    n_cmp++; if (mif.rsp_valid_o !== 1'b0 || mif.rsp_last_o !== 1'b0 || mif.rsp_rdata_o !== 32'h0) begin
      n_bad++; $display("FAIL rmb_rsp got v=%b l=%b d=%h want 0/0/0", mif.rsp_valid_o, mif.rsp_last_o, mif.rsp_rdata_o);
    end
    n_cmp++; if (mif.mem_addr_o !== 32'h0 || mif.mem_we_o !== 1'b0) begin n_bad++; $display("FAIL rmb_mem got a=%h we=%b want 0/0", mif.mem_addr_o, mif.mem_we_o); end
    n_cmp++; if (mif.req_ready_o !== 1'b1) begin n_bad++; $display("FAIL rmb_ready got %b want 1", mif.req_ready_o); end
    #1 reset = 1'b0;
    run_txn(1'b0, 1'b0, 32'h1000_0200, 32'h0, 1, 0, 0, 1'b0);
    n_cmp++; if (ob_data.size() != 2 || ob_timeout !== 1'b0) begin n_bad++; $display("FAIL rmb_after_beats got %0d want 2", ob_data.size()); end
    else begin
      n_cmp++; if (ob_data[1] !== ref_rd(32'h1000_0204) || ob_last[1] !== 1'b1) begin n_bad++; $display("FAIL rmb_after_data got %h want %h", ob_data[1], ref_rd(32'h1000_0204)); end
    end
    n_cmp++; if (we_cnt != we0) begin n_bad++; $display("FAIL rmb_writes got %0d want %0d", we_cnt, we0); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, a2;
    a1 = 32'h1000_0000 + 32'(4 * $urandom_range(0, 63));
    a2 = 32'h1000_0400 + 32'(4 * $urandom_range(0, 63));
    run_txn(1'b0, 1'b0, a1, 32'h0, 1, 0, 0, 1'b1);
    n_cmp++; if (ob_busy_rdy != 0) begin n_bad++; $display("FAIL b2b_busy_ready got %0d want 0", ob_busy_rdy); end
    n_cmp++; if (ob_data.size() != 2 || ob_data[ob_data.size()-1] !== ref_rd(a1 + 32'd4)) begin n_bad++; $display("FAIL b2b_first_data got beats=%0d want 2", ob_data.size()); end
    n_cmp++; if (ob_done_rdy !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_after got %b want 1", ob_done_rdy); end
    run_txn(1'b1, 1'b0, a2, 32'h0, 2, 0, 0, 1'b0);
    n_cmp++; if (ob_accept_rdy !== 1'b1 || ob_lat != 2) begin n_bad++; $display("FAIL b2b_second got rdy=%b lat=%0d want 1/2", ob_accept_rdy, ob_lat); end
    n_cmp++; if (ob_data.size() != 3 || ob_data[0] !== ref_rd(a2)) begin n_bad++; $display("FAIL b2b_second_data got beats=%0d want 3", ob_data.size()); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      bit w, e;
      int len, exp_n;
      logic [31:0] a, wd;
      w  = 1'($urandom_range(0, 1));
      wd = $urandom;
      case ($urandom_range(0, 5))
        0:       a = 32'(4 * $urandom_range(0, 1023));
        1, 5:    a = 32'h1000_0000 + 32'(4 * $urandom_range(0, 31));
        2:       a = 32'h1000_0000 - 32'(4 * $urandom_range(0, 8));
        3:       a = 32'hFFFF_FFFC - 32'(4 * $urandom_range(0, 8));
        default: a = 32'h1000_0000 + 32'($urandom_range(1, 127));
      endcase
      len = (w && $urandom_range(0, 4) != 0) ? 0 : int'($urandom_range(0, 7));
      run_txn(1'b0, w, a, wd, len, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
      e = model_err(w, a, len);
      exp_n = (e || w) ? 1 : len + 1;
      n_cmp++; if (ob_timeout !== 1'b0 || ob_data.size() != exp_n) begin n_bad++; $display("FAIL rnd%0d_beats a=%h w=%b len=%0d got %0d want %0d", t, a, w, len, ob_data.size(), exp_n); end
      n_cmp++; if (ob_lat != (e ? 1 : 2)) begin n_bad++; $display("FAIL rnd%0d_latency got %0d want %0d", t, ob_lat, e ? 1 : 2); end
      n_cmp++; if (ob_we != ((!e && w) ? 1 : 0)) begin n_bad++; $display("FAIL rnd%0d_we got %0d want %0d", t, ob_we, (!e && w) ? 1 : 0); end
      if (!e && w) begin
        n_cmp++; if (ob_we_addr !== a || ob_we_data !== wd) begin n_bad++; $display("FAIL rnd%0d_wbus got %h/%h want %h/%h", t, ob_we_addr, ob_we_data, a, wd); end
        ref_mem[a] = wd;
      end
      for (int i = 0; i < ob_data.size() && i < exp_n; i++) begin
        logic [31:0] ed;
        ed = (e || w) ? 32'h0 : ref_rd(a + 32'(4 * i));
        n_cmp++; if (ob_data[i] !== ed || ob_err[i] !== e || ob_last[i] !== (i == exp_n - 1)) begin
          n_bad++; $display("FAIL rnd%0d_beat%0d got %h/%b/%b want %h/%b/%b", t, i, ob_data[i], ob_err[i], ob_last[i], ed, e, i == exp_n - 1);
        end
        if (!e && !w) begin
          n_cmp++; if (ob_addr[i] !== a + 32'(4 * i)) begin n_bad++; $display("FAIL rnd%0d_addr%0d got %h want %h", t, i, ob_addr[i], a + 32'(4 * i)); end
        end
      end
      n_cmp++; if (ob_unstable != 0 || ob_gap_bad != 0 || ob_busy_rdy != 0) begin
        n_bad++; $display("FAIL rnd%0d_protocol got unstable=%0d gaps=%0d busyrdy=%0d want 0/0/0", t, ob_unstable, ob_gap_bad, ob_busy_rdy);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    mif.req_valid_i = 1'b0; mif.req_write_i = 1'b0; mif.req_addr_i = '0;
    mif.req_wdata_i = '0; mif.req_len_i = '0; mif.rsp_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    test_read_rom();
    test_write_ram();
    test_burst_stall();
    test_errors();
    test_reset_mid_burst();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
